// File: rtl/keypad_scan_decoder_if.sv
// Keypad matrix signals plus the decoded key event outputs.
// The decoder drives the columns and key outputs; the keypad side returns the rows.
interface keypad_scan_decoder_if;
   logic [3:0] row_in;
   logic [3:0] col_sel;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  row_in,
      output col_sel,
      output key_code,
      output key_valid,
      output key_held
   );

   modport slave (
      output row_in,
      input  col_sel,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scan_decoder.sv
// 4x4 keypad column scanner with frame-level debounce.
// Emits one key_valid pulse per accepted press and tracks the held state.
module keypad_scan_decoder #(
   parameter int unsigned SCAN_DIV        = 16,
   parameter int unsigned DEBOUNCE_FRAMES = 3
) (
   input logic                   clk_in,
   input logic                   reset,
   keypad_scan_decoder_if.master kp
);

   localparam int unsigned   DivW    = $clog2(SCAN_DIV);
   localparam int unsigned   CntW    = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_FRAMES);

   typedef enum logic [1:0] {StIdle, StPressDb, StHeld} state_e;

   state_e          state_q, state_d;
   logic [3:0]      row_meta_q, row_meta_d;
   logic [3:0]      row_sync_q, row_sync_d;
   logic [DivW-1:0] div_q, div_d;
   logic [1:0]      col_q, col_d;
   logic [3:0]      col_sel_q, col_sel_d;
   logic [1:0]      acc_cnt_q, acc_cnt_d;
   logic [3:0]      acc_key_q, acc_key_d;
   logic [3:0]      cand_q, cand_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      key_code_q, key_code_d;
   logic            key_valid_q, key_valid_d;
   logic            key_held_q, key_held_d;

   logic            sample, frame_end, frame_valid, accept;
   logic [3:0]      rows_low, acc_key_new;
   logic [2:0]      n_low, tot;
   logic [1:0]      low_idx, acc_cnt_sat;
   logic [CntW-1:0] cnt_inc;

   always_comb begin
      state_d     = state_q;
      row_meta_d  = kp.row_in;
      row_sync_d  = row_meta_q;
      div_d       = div_q;
      col_d       = col_q;
      col_sel_d   = col_sel_q;
      acc_cnt_d   = acc_cnt_q;
      acc_key_d   = acc_key_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      accept      = 1'b0;

      sample    = (div_q == DivLast);
      frame_end = sample && (col_q == 2'd3);
      div_d     = sample ? '0 : div_q + 1'b1;
      if (sample) begin
         col_d     = col_q + 2'd1;
         col_sel_d = ~(4'b0001 << col_d);
      end

      rows_low = ~row_sync_q;
      n_low    = '0;
      low_idx  = '0;
      for (int i = 0; i < 4; i++) begin
         n_low = n_low + {2'b00, rows_low[i]};
         if (rows_low[i]) low_idx = i[1:0];
      end
      // Saturate at 2: anything beyond one low bit per frame means ghosting/multi-press.
      tot         = {1'b0, acc_cnt_q} + n_low;
      acc_cnt_sat = (tot >= 3'd2) ? 2'd2 : tot[1:0];
      acc_key_new = (acc_cnt_q == 2'd0 && n_low == 3'd1) ? {col_q, low_idx} : acc_key_q;
      frame_valid = (acc_cnt_sat == 2'd1);

      if (frame_end) begin
         acc_cnt_d = '0;
         acc_key_d = '0;
      end else if (sample) begin
         acc_cnt_d = acc_cnt_sat;
         acc_key_d = acc_key_new;
      end

      cnt_inc = cnt_q + 1'b1;
      if (frame_end) begin
         unique case (state_q)
            StIdle: begin
               if (frame_valid) begin
                  cand_d = acc_key_new;
                  if (DEBOUNCE_FRAMES == 1) begin
                     accept = 1'b1;
                  end else begin
                     cnt_d   = CntW'(1);
                     state_d = StPressDb;
                  end
               end
            end
            StPressDb: begin
               if (!frame_valid) begin
                  cnt_d   = '0;
                  state_d = StIdle;
               end else if (acc_key_new == cand_q) begin
                  if (cnt_inc == CntDone) accept = 1'b1;
                  else                    cnt_d  = cnt_inc;
               end else begin
                  cand_d = acc_key_new;
                  cnt_d  = CntW'(1);
               end
            end
            StHeld: begin
               if (frame_valid || acc_cnt_sat != 2'd0) begin
                  cnt_d = '0;
               end else if (cnt_inc == CntDone) begin
                  cnt_d      = '0;
                  key_held_d = 1'b0;
                  state_d    = StIdle;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      if (accept) begin
         key_code_d  = cand_d;
         key_held_d  = 1'b1;
         key_valid_d = 1'b1;
         cnt_d       = '0;
         state_d     = StHeld;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q     <= StIdle;
         row_meta_q  <= 4'hF;
         row_sync_q  <= 4'hF;
         div_q       <= '0;
         col_q       <= '0;
         col_sel_q   <= 4'b1110;
         acc_cnt_q   <= '0;
         acc_key_q   <= '0;
         cand_q      <= '0;
         cnt_q       <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_meta_q  <= row_meta_d;
         row_sync_q  <= row_sync_d;
         div_q       <= div_d;
         col_q       <= col_d;
         col_sel_q   <= col_sel_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_key_q   <= acc_key_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign kp.col_sel   = col_sel_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Directed bench for keypad_scan_decoder with a behavioural 4x4 keypad matrix.
// SCAN_DIV=4, DEBOUNCE_FRAMES=2: one frame is 16 clock cycles.
module tb_keypad_scan_decoder;

   logic        clk_in = 1'b0;
   logic        reset  = 1'b1;
   logic [15:0] keys   = '0;
   logic [3:0]  row_drv;
   int          passed = 0;
   int          total  = 0;
   int          valid_cycles = 0;

   keypad_scan_decoder_if kb ();

   keypad_scan_decoder #(
      .SCAN_DIV       (4),
      .DEBOUNCE_FRAMES(2)
   ) dut (
      .clk_in(clk_in),
      .reset (reset),
      .kp    (kb)
   );

   always #5 clk_in = ~clk_in;

   // Key index {col,row}: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row_drv = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4+r] && !kb.col_sel[c]) row_drv[r] = 1'b0;
   end
   assign kb.row_in = row_drv;

   // Counts cycles with key_valid high; a stretched pulse shows up as an extra count.
   always @(posedge clk_in) if (kb.key_valid === 1'b1) valid_cycles++;

   task automatic step(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      keys  = '0;
      step(3);
      total++; if (kb.col_sel !== 4'b1110) $display("FAIL reset_col_sel got %b exp 1110", kb.col_sel); else passed++;
      total++; if (kb.key_code !== 4'h0) $display("FAIL reset_key_code got %h exp 0", kb.key_code); else passed++;
      total++; if (kb.key_valid !== 1'b0) $display("FAIL reset_key_valid got %b exp 0", kb.key_valid); else passed++;
      total++; if (kb.key_held !== 1'b0) $display("FAIL reset_key_held got %b exp 0", kb.key_held); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_scan;
      logic [3:0] exp_sel;
      for (int i = 0; i <= 16; i++) begin
         exp_sel = ~(4'b0001 << ((i / 4) % 4));
         total++;
         if (kb.col_sel !== exp_sel)
            $display("FAIL scan_col_sel cycle %0d got %b exp %b", i, kb.col_sel, exp_sel);
         else passed++;
         step(1);
      end
      step(15);
   endtask

   task automatic test_press_release;
      int v0 = valid_cycles;
      keys[9] = 1'b1;
      step(32);
      total++; if (kb.key_valid !== 1'b1) $display("FAIL press_valid got %b exp 1", kb.key_valid); else passed++;
      total++; if (kb.key_code !== 4'h9) $display("FAIL press_code got %h exp 9", kb.key_code); else passed++;
      total++; if (kb.key_held !== 1'b1) $display("FAIL press_held got %b exp 1", kb.key_held); else passed++;
      step(1);
      total++; if (kb.key_valid !== 1'b0) $display("FAIL press_valid_drop got %b exp 0", kb.key_valid); else passed++;
      step(15);
      keys = '0;
      step(16);
      total++; if (kb.key_held !== 1'b1) $display("FAIL release1_held got %b exp 1", kb.key_held); else passed++;
      step(16);
      total++; if (kb.key_held !== 1'b0) $display("FAIL release2_held got %b exp 0", kb.key_held); else passed++;
      total++; if (kb.key_code !== 4'h9) $display("FAIL release_code got %h exp 9", kb.key_code); else passed++;
      total++; if (valid_cycles - v0 !== 1) $display("FAIL press_pulses got %0d exp 1", valid_cycles - v0); else passed++;
   endtask

   task automatic test_bounce;
      int v0 = valid_cycles;
      keys[9] = 1'b1;
      step(16);
      keys = '0;
      step(48);
      total++; if (kb.key_held !== 1'b0) $display("FAIL bounce_held got %b exp 0", kb.key_held); else passed++;
      total++; if (valid_cycles - v0 !== 0) $display("FAIL bounce_pulses got %0d exp 0", valid_cycles - v0); else passed++;
   endtask

   task automatic test_multi_press;
      int v0 = valid_cycles;
      keys[2] = 1'b1;
      keys[9] = 1'b1;
      step(64);
      total++; if (valid_cycles - v0 !== 0) $display("FAIL multi_pulses got %0d exp 0", valid_cycles - v0); else passed++;
      total++; if (kb.key_held !== 1'b0) $display("FAIL multi_held got %b exp 0", kb.key_held); else passed++;
      for (int f = 0; f < 6; f++) begin
         keys = '0;
         if (f % 2 == 0) keys[2] = 1'b1;
         else            keys[9] = 1'b1;
         step(16);
      end
      keys = '0;
      step(16);
      total++; if (valid_cycles - v0 !== 0) $display("FAIL alt_pulses got %0d exp 0", valid_cycles - v0); else passed++;
      total++; if (kb.key_held !== 1'b0) $display("FAIL alt_held got %b exp 0", kb.key_held); else passed++;
      keys[2] = 1'b1;
      step(32);
      total++; if (kb.key_valid !== 1'b1) $display("FAIL key2_valid got %b exp 1", kb.key_valid); else passed++;
      total++; if (kb.key_code !== 4'h2) $display("FAIL key2_code got %h exp 2", kb.key_code); else passed++;
      keys = '0;
      step(32);
      total++; if (kb.key_held !== 1'b0) $display("FAIL key2_release got %b exp 0", kb.key_held); else passed++;
   endtask

   task automatic test_reset_held;
      int v0;
      keys[9] = 1'b1;
      step(32);
      total++; if (kb.key_valid !== 1'b1) $display("FAIL held_valid got %b exp 1", kb.key_valid); else passed++;
      step(21);
      total++; if (kb.key_held !== 1'b1) $display("FAIL held_before_reset got %b exp 1", kb.key_held); else passed++;
      reset = 1'b1;
      step(1);
      total++; if (kb.key_held !== 1'b0) $display("FAIL rst_held got %b exp 0", kb.key_held); else passed++;
      total++; if (kb.key_code !== 4'h0) $display("FAIL rst_code got %h exp 0", kb.key_code); else passed++;
      total++; if (kb.key_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", kb.key_valid); else passed++;
      total++; if (kb.col_sel !== 4'b1110) $display("FAIL rst_col_sel got %b exp 1110", kb.col_sel); else passed++;
      reset = 1'b0;
      v0 = valid_cycles;
      step(31);
      total++; if (kb.key_held !== 1'b0) $display("FAIL redb_early_held got %b exp 0", kb.key_held); else passed++;
      total++; if (valid_cycles - v0 !== 0) $display("FAIL redb_early_pulses got %0d exp 0", valid_cycles - v0); else passed++;
      step(1);
      total++; if (kb.key_valid !== 1'b1) $display("FAIL redb_valid got %b exp 1", kb.key_valid); else passed++;
      total++; if (kb.key_code !== 4'h9) $display("FAIL redb_code got %h exp 9", kb.key_code); else passed++;
      keys = '0;
      step(48);
      total++; if (valid_cycles - v0 !== 1) $display("FAIL redb_pulses got %0d exp 1", valid_cycles - v0); else passed++;
   endtask

   initial begin
      test_reset();
      test_scan();
      test_press_release();
      test_bounce();
      test_multi_press();
      test_reset_held();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
